// File: rtl/ddram_arbiter_pkg.sv
// rtl/ddram_arbiter_pkg.sv - shared state encoding and DDR port widths for the ram1 arbiter
package ddram_arbiter_pkg;
    localparam int DDR_ADDR_W  = 29;
    localparam int DDR_DATA_W  = 64;
    localparam int DDR_BURST_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_CMD,
        READ_DATA
    } state_t;
endpackage

// File: rtl/ddram_rr_pick.sv
// rtl/ddram_rr_pick.sv - two-way round-robin select, favouring the requester not served last
module ddram_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick
);
    // With no request the result is don't-care; the caller gates on req0|req1.
    assign pick = (req0 && req1) ? ~last : req1;
endmodule

// File: rtl/ddram_arbiter.sv
// rtl/ddram_arbiter.sv - whole-burst, round-robin arbiter sharing one Avalon-MM DDR3 port between two clients
module ddram_arbiter
    import ddram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DDR_ADDR_W,
    parameter int DATA_W  = DDR_DATA_W,
    parameter int BURST_W = DDR_BURST_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rq0_addr,
    input  logic [BURST_W-1:0]  rq0_burstcnt,
    input  logic                rq0_rd,
    input  logic                rq0_we,
    input  logic [DATA_W-1:0]   rq0_din,
    input  logic [DATA_W/8-1:0] rq0_be,
    output logic                rq0_busy,
    output logic [DATA_W-1:0]   rq0_dout,
    output logic                rq0_dout_ready,
    input  logic [ADDR_W-1:0]   rq1_addr,
    input  logic [BURST_W-1:0]  rq1_burstcnt,
    input  logic                rq1_rd,
    input  logic                rq1_we,
    input  logic [DATA_W-1:0]   rq1_din,
    input  logic [DATA_W/8-1:0] rq1_be,
    output logic                rq1_busy,
    output logic [DATA_W-1:0]   rq1_dout,
    output logic                rq1_dout_ready,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [BURST_W-1:0]  ram_burstcount,
    output logic                ram_read,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    input  logic                ram_waitrequest,
    input  logic [DATA_W-1:0]   ram_readdata,
    input  logic                ram_readdatavalid
);
    state_t             state, next_state;
    logic               grant, next_grant;
    logic               last_grant, next_last_grant;
    logic [BURST_W-1:0] len, next_len;
    logic [BURST_W-1:0] cnt, next_cnt;
    logic               req0, req1, pick, pick_we, sel_we;
    logic [BURST_W-1:0] pick_burst;
    logic               grant_busy, grant_ready;

    assign req0 = rq0_rd | rq0_we;
    assign req1 = rq1_rd | rq1_we;

    ddram_rr_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_grant),
        .pick (pick)
    );

    assign pick_we    = pick ? rq1_we : rq0_we;
    assign pick_burst = pick ? rq1_burstcnt : rq0_burstcnt;
    assign sel_we     = grant ? rq1_we : rq0_we;

    // Command and write-data path follow the granted client; the client holds them stable.
    assign ram_address    = grant ? rq1_addr : rq0_addr;
    assign ram_burstcount = grant ? rq1_burstcnt : rq0_burstcnt;
    assign ram_writedata  = grant ? rq1_din : rq0_din;
    assign ram_byteenable = grant ? rq1_be : rq0_be;

    assign rq0_dout       = ram_readdata;
    assign rq1_dout       = ram_readdata;
    assign rq0_busy       = grant ? 1'b1 : grant_busy;
    assign rq1_busy       = grant ? grant_busy : 1'b1;
    assign rq0_dout_ready = ~grant & grant_ready;
    assign rq1_dout_ready = grant & grant_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            len        <= '0;
            cnt        <= '0;
        end else begin
            state      <= next_state;
            grant      <= next_grant;
            last_grant <= next_last_grant;
            len        <= next_len;
            cnt        <= next_cnt;
        end
    end

    always_comb begin
        next_state      = state;
        next_grant      = grant;
        next_last_grant = last_grant;
        next_len        = len;
        next_cnt        = cnt;
        ram_read        = 1'b0;
        ram_write       = 1'b0;
        grant_busy      = 1'b1;
        grant_ready     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_grant      = pick;
                    next_last_grant = pick;
                    next_len        = (pick_burst == '0) ? BURST_W'(1) : pick_burst;
                    next_cnt        = '0;
                    next_state      = pick_we ? WRITE : READ_CMD;
                end
            end
            WRITE: begin
                ram_write  = sel_we;
                grant_busy = ram_waitrequest;
                if (sel_we && !ram_waitrequest) begin
                    next_cnt = cnt + BURST_W'(1);
                    if (cnt == len - BURST_W'(1)) begin
                        next_cnt   = '0;
                        next_state = IDLE;
                    end
                end
            end
            READ_CMD: begin
                ram_read   = 1'b1;
                grant_busy = ram_waitrequest;
                if (!ram_waitrequest) begin
                    next_cnt   = '0;
                    next_state = READ_DATA;
                    // A beat already returning in the acceptance cycle belongs to this burst.
                    if (ram_readdatavalid) begin
                        grant_ready = 1'b1;
                        next_cnt    = BURST_W'(1);
                        if (len == BURST_W'(1)) begin
                            next_cnt   = '0;
                            next_state = IDLE;
                        end
                    end
                end
            end
            READ_DATA: begin
                if (ram_readdatavalid) begin
                    grant_ready = 1'b1;
                    next_cnt    = cnt + BURST_W'(1);
                    if (cnt == len - BURST_W'(1)) begin
                        next_cnt   = '0;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule
